// File: rtl/sme_multi.sv
// ---------------------------------------------------------------------------
// sme_multi : successor string-matching engine
//
// Stores one string, then matches any number of patterns against it without
// reloading the string. Pattern syntax: literal characters, '.' (any char),
// a leading '^' (match only at string start or just after a space), '$'
// (string end or before a space, consumes nothing) and any number of '*'
// (zero or more chars, resolved by backtracking to the most recent star).
// The leftmost match is reported with its start index and length.
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   asynchronous active-high reset
//   chardata     in   character in (CHAR_W bits)
//   isstring     in   chardata is a string character this cycle
//   ispattern    in   chardata is a pattern character this cycle
//   busy         out  scan in progress; host must not stream
//   valid        out  one-cycle result strobe
//   match        out  pattern found (qualified by valid, held until next result)
//   match_index  out  start position of the match, 0 if none
//   match_len    out  number of string chars spanned, 0 if none
//   str_ovf      out  sticky: last string exceeded STR_MAX chars
//
// Optional feature macro: SME_MULTI_NOCASE_EN
//   defined   -> literal compares fold ASCII A-Z onto a-z (low 8 bits only)
//   undefined -> exact CHAR_W-bit compare
// ---------------------------------------------------------------------------
module sme_multi #(
    parameter int CHAR_W  = 8,
    parameter int STR_MAX = 32,
    parameter int PAT_MAX = 8,
    parameter int IDX_W   = $clog2(STR_MAX + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CHAR_W-1:0] chardata,
    input  logic              isstring,
    input  logic              ispattern,
    output logic              busy,
    output logic              valid,
    output logic              match,
    output logic [IDX_W-1:0]  match_index,
    output logic [IDX_W-1:0]  match_len,
    output logic              str_ovf
);

    // One extra bit so a start position of slen+1 can be represented.
    localparam int CW   = IDX_W + 1;
    localparam int SA_W = (STR_MAX > 1) ? $clog2(STR_MAX) : 1;
    localparam int PA_W = (PAT_MAX > 1) ? $clog2(PAT_MAX) : 1;
    localparam int PI_W = $clog2(PAT_MAX + 1);

    localparam logic [CW-1:0]     L_SMAX   = CW'(STR_MAX);
    localparam logic [PI_W-1:0]   L_PMAX   = PI_W'(PAT_MAX);
    localparam logic [CHAR_W-1:0] C_SPACE  = CHAR_W'(8'h20);
    localparam logic [CHAR_W-1:0] C_DOLLAR = CHAR_W'(8'h24);
    localparam logic [CHAR_W-1:0] C_STAR   = CHAR_W'(8'h2A);
    localparam logic [CHAR_W-1:0] C_DOT    = CHAR_W'(8'h2E);
    localparam logic [CHAR_W-1:0] C_CARET  = CHAR_W'(8'h5E);

    typedef enum logic [2:0] {
        IDLE,
        RECV_S,
        RECV_P,
        SCAN,
        DONE
    } state_t;

    state_t r_state, w_next;

    logic [CHAR_W-1:0] r_str [STR_MAX];
    logic [CHAR_W-1:0] r_pat [PAT_MAX];

    logic [CW-1:0]   r_slen;
    logic [PI_W-1:0] r_plen;
    logic            r_ovf;

    // Scan state
    logic [CW-1:0]   r_st, r_si, r_star_s, r_first;
    logic [PI_W-1:0] r_pi, r_pstart, r_star_p;
    logic            r_star_seen, r_first_set, r_star_first_set, r_anch;

    // Result registers
    logic             r_match;
    logic [IDX_W-1:0] r_idx, r_len;

    // ---------------------------------------------------------------------
    // Helper functions
    // ---------------------------------------------------------------------
    function automatic logic [CW-1:0] sat_inc_s(input logic [CW-1:0] v);
        return (v >= L_SMAX) ? v : v + 1'b1;
    endfunction

    function automatic logic [PI_W-1:0] sat_inc_p(input logic [PI_W-1:0] v);
        return (v >= L_PMAX) ? v : v + 1'b1;
    endfunction

    function automatic logic [CHAR_W-1:0] fold(input logic [CHAR_W-1:0] c);
        logic [CHAR_W-1:0] v;
        v = c;
`ifdef SME_MULTI_NOCASE_EN
        if (c[7:0] >= 8'h41 && c[7:0] <= 8'h5A) v[5] = 1'b1;
`endif
        return v;
    endfunction

    // ---------------------------------------------------------------------
    // Character fetch and start legality
    // ---------------------------------------------------------------------
    logic [CHAR_W-1:0] w_sc, w_pc, w_prev;
    logic              w_legal, w_at_start, w_anch0;
    logic [PI_W-1:0]   w_pstart0;

    assign w_sc   = (r_si < L_SMAX) ? r_str[SA_W'(r_si)] : '0;
    assign w_pc   = (r_pi < L_PMAX) ? r_pat[PA_W'(r_pi)] : '0;
    // st >= 1 whenever this is consulted, and st-1 < slen <= STR_MAX.
    assign w_prev = r_str[SA_W'(r_st - 1'b1)];

    assign w_legal    = !r_anch || (r_st == '0) || (w_prev == C_SPACE);
    // pi only returns to pstart without a star on a fresh attempt from st.
    assign w_at_start = (r_pi == r_pstart) && !r_star_seen;

    assign w_anch0   = (r_plen != '0) && (r_pat[0] == C_CARET);
    assign w_pstart0 = w_anch0 ? PI_W'(1) : '0;

    // ---------------------------------------------------------------------
    // Scan step: one comparison per cycle
    // ---------------------------------------------------------------------
    logic [CW-1:0]   n_st, n_si, n_star_s, n_first;
    logic [PI_W-1:0] n_pi, n_star_p;
    logic            n_star_seen, n_first_set, n_star_first_set;
    logic            w_done, w_hit, w_mis;
    logic [CW-1:0]   w_idx, w_len;

    always_comb begin
        n_st             = r_st;
        n_si             = r_si;
        n_pi             = r_pi;
        n_star_p         = r_star_p;
        n_star_s         = r_star_s;
        n_star_seen      = r_star_seen;
        n_first          = r_first;
        n_first_set      = r_first_set;
        n_star_first_set = r_star_first_set;
        w_done           = 1'b0;
        w_hit            = 1'b0;
        w_mis            = 1'b0;

        if (r_st > r_slen) begin
            w_done = 1'b1;
        end else if (w_at_start && !w_legal) begin
            // anchored pattern: skip starts that do not follow a space
            n_st = r_st + 1'b1;
            n_si = r_st + 1'b1;
        end else if (r_pi == r_plen) begin
            w_done = 1'b1;
            w_hit  = 1'b1;
        end else if (w_pc == C_STAR) begin
            n_star_p         = r_pi + 1'b1;
            n_star_s         = r_si;
            n_star_seen      = 1'b1;
            n_star_first_set = r_first_set;
            n_pi             = r_pi + 1'b1;
        end else if (w_pc == C_DOLLAR) begin
            if (r_si == r_slen || w_sc == C_SPACE) n_pi = r_pi + 1'b1;
            else                                    w_mis = 1'b1;
        end else if (r_si == r_slen) begin
            // literal left with no string: no later start or star can help
            w_done = 1'b1;
        end else if (w_pc == C_DOT || fold(w_pc) == fold(w_sc)) begin
            n_si = r_si + 1'b1;
            n_pi = r_pi + 1'b1;
            if (!r_first_set) begin
                n_first     = r_si;
                n_first_set = 1'b1;
            end
        end else begin
            w_mis = 1'b1;
        end

        if (w_mis) begin
            if (r_star_seen) begin
                // let the last star swallow one more char; chars consumed
                // after it are redone, so restore the first-consumed marker
                n_star_s    = r_star_s + 1'b1;
                n_si        = r_star_s + 1'b1;
                n_pi        = r_star_p;
                n_first_set = r_star_first_set;
            end else begin
                n_st        = r_st + 1'b1;
                n_si        = r_st + 1'b1;
                n_pi        = r_pstart;
                n_first_set = 1'b0;
            end
        end
    end

    // A leading star makes the match start at the first consumed char.
    assign w_idx = (r_pat[0] == C_STAR) ? (r_first_set ? r_first : r_si) : r_st;
    assign w_len = r_si - w_idx;

    // ---------------------------------------------------------------------
    // FSM: next state and storage write enables
    // ---------------------------------------------------------------------
    logic            w_str_we, w_pat_we;
    logic [SA_W-1:0] w_str_wa;
    logic [PA_W-1:0] w_pat_wa;

    always_comb begin
        w_next   = r_state;
        w_str_we = 1'b0;
        w_pat_we = 1'b0;
        w_str_wa = '0;
        w_pat_wa = '0;
        case (r_state)
            IDLE, DONE: begin
                if (isstring) begin
                    w_next   = RECV_S;
                    w_str_we = 1'b1;
                end else if (ispattern) begin
                    w_next   = RECV_P;
                    w_pat_we = 1'b1;
                end else begin
                    w_next = IDLE;
                end
            end
            RECV_S: begin
                if (isstring) begin
                    w_str_we = (r_slen < L_SMAX);
                    w_str_wa = SA_W'(r_slen);
                end else if (ispattern) begin
                    w_next   = RECV_P;
                    w_pat_we = 1'b1;
                end else begin
                    w_next = IDLE;
                end
            end
            RECV_P: begin
                if (ispattern) begin
                    w_pat_we = (r_plen < L_PMAX);
                    w_pat_wa = PA_W'(r_plen);
                end else begin
                    w_next = SCAN;
                end
            end
            SCAN: begin
                if (w_done) w_next = DONE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // Character storage carries no reset; lengths decide what is valid.
    always_ff @(posedge clk) begin
        if (w_str_we) r_str[w_str_wa] <= chardata;
        if (w_pat_we) r_pat[w_pat_wa] <= chardata;
    end

    // ---------------------------------------------------------------------
    // Lengths, scan registers and results
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_slen           <= '0;
            r_plen           <= '0;
            r_ovf            <= 1'b0;
            r_st             <= '0;
            r_si             <= '0;
            r_star_s         <= '0;
            r_first          <= '0;
            r_pi             <= '0;
            r_pstart         <= '0;
            r_star_p         <= '0;
            r_star_seen      <= 1'b0;
            r_first_set      <= 1'b0;
            r_star_first_set <= 1'b0;
            r_anch           <= 1'b0;
            r_match          <= 1'b0;
            r_idx            <= '0;
            r_len            <= '0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (isstring) begin
                        r_slen <= CW'(1);
                        r_ovf  <= 1'b0;
                    end else if (ispattern) begin
                        r_plen <= PI_W'(1);
                    end
                end
                RECV_S: begin
                    if (isstring) begin
                        if (r_slen >= L_SMAX) r_ovf <= 1'b1;
                        r_slen <= sat_inc_s(r_slen);
                    end else if (ispattern) begin
                        r_plen <= PI_W'(1);
                    end
                end
                RECV_P: begin
                    if (ispattern) begin
                        r_plen <= sat_inc_p(r_plen);
                    end else begin
                        // scan setup; a leading '^' is consumed here
                        r_st             <= '0;
                        r_si             <= '0;
                        r_star_s         <= '0;
                        r_first          <= '0;
                        r_anch           <= w_anch0;
                        r_pstart         <= w_pstart0;
                        r_pi             <= w_pstart0;
                        r_star_p         <= '0;
                        r_star_seen      <= 1'b0;
                        r_first_set      <= 1'b0;
                        r_star_first_set <= 1'b0;
                    end
                end
                SCAN: begin
                    r_st             <= n_st;
                    r_si             <= n_si;
                    r_pi             <= n_pi;
                    r_star_p         <= n_star_p;
                    r_star_s         <= n_star_s;
                    r_star_seen      <= n_star_seen;
                    r_first          <= n_first;
                    r_first_set      <= n_first_set;
                    r_star_first_set <= n_star_first_set;
                    if (w_done) begin
                        r_match <= w_hit;
                        r_idx   <= w_hit ? IDX_W'(w_idx) : '0;
                        r_len   <= w_hit ? IDX_W'(w_len) : '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy        = (r_state == SCAN);
    assign valid       = (r_state == DONE);
    assign match       = r_match;
    assign match_index = r_idx;
    assign match_len   = r_len;
    assign str_ovf     = r_ovf;

endmodule

// File: tb/tb_sme_multi.sv
module tb_sme_multi;

    localparam int CHAR_W  = 8;
    localparam int STR_MAX = 32;
    localparam int PAT_MAX = 8;
    localparam int IDX_W   = 6;

    logic              clk = 1'b0;
    logic              reset;
    logic [CHAR_W-1:0] chardata;
    logic              isstring, ispattern;
    logic              busy, valid, match, str_ovf;
    logic [IDX_W-1:0]  match_index, match_len;

    always #5 clk = ~clk;

    sme_multi #(
        .CHAR_W (CHAR_W),
        .STR_MAX(STR_MAX),
        .PAT_MAX(PAT_MAX),
        .IDX_W  (IDX_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .chardata   (chardata),
        .isstring   (isstring),
        .ispattern  (ispattern),
        .busy       (busy),
        .valid      (valid),
        .match      (match),
        .match_index(match_index),
        .match_len  (match_len),
        .str_ovf    (str_ovf)
    );

    typedef struct packed {
        logic             m;
        logic [IDX_W-1:0] idx;
        logic [IDX_W-1:0] len;
    } res_t;

    res_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    logic prev_valid = 1'b0;

    task automatic chk(input bit ok, input string name, input int act, input int exp);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pops one expected result per valid strobe
    always @(negedge clk) begin
        if (valid === 1'b1) begin
            chk(prev_valid !== 1'b1, "valid_one_cycle", int'(prev_valid), 0);
            chk(busy === 1'b0, "busy_low_at_valid", int'(busy), 0);
            if (exp_q.size() == 0) begin
                chk(1'b0, "unexpected_valid", 1, 0);
            end else begin
                chk(match === exp_q[0].m, "match", int'(match), int'(exp_q[0].m));
                chk(match_index === exp_q[0].idx, "match_index", int'(match_index), int'(exp_q[0].idx));
                chk(match_len === exp_q[0].len, "match_len", int'(match_len), int'(exp_q[0].len));
                exp_q.delete(0);
            end
        end
        prev_valid <= valid;
    end

    task automatic put(input logic [7:0] c, input bit s, input bit p);
        chardata  = c;
        isstring  = s;
        ispattern = p;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        chardata  = '0;
        isstring  = 1'b0;
        ispattern = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) put(s[i], 1'b1, 1'b0);
        idle_in();
        @(posedge clk);
        #1;
    endtask

    task automatic load_pat(input string p, input bit m, input int idx, input int len);
        res_t e;
        e.m   = m;
        e.idx = IDX_W'(idx);
        e.len = IDX_W'(len);
        exp_q.push_back(e);
        for (int i = 0; i < p.len(); i++) put(p[i], 1'b0, 1'b1);
        idle_in();
    endtask

    task automatic wait_done(input string name);
        @(posedge clk);
        #1;
        chk(busy === 1'b1, {name, "_busy"}, int'(busy), 1);
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (valid === 1'b1) return;
        end
        chk(1'b0, {name, "_timeout"}, 0, 1);
    endtask

    initial begin
        string s40;
        reset = 1'b1;
        idle_in();
        repeat (2) @(posedge clk);
        #1;
        chk(valid === 1'b0, "rst_valid", int'(valid), 0);
        chk(busy === 1'b0, "rst_busy", int'(busy), 0);
        chk(match === 1'b0, "rst_match", int'(match), 0);
        chk(match_index === '0, "rst_index", int'(match_index), 0);
        chk(match_len === '0, "rst_len", int'(match_len), 0);
        chk(str_ovf === 1'b0, "rst_ovf", int'(str_ovf), 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        send_str("hello world");
        chk(str_ovf === 1'b0, "ovf_short", int'(str_ovf), 0);
        load_pat("wor", 1'b1, 6, 3);     wait_done("wor");
        load_pat("^wor", 1'b1, 6, 3);    wait_done("anch_wor");
        // next pattern streamed during the DONE cycle
        load_pat("ld$", 1'b1, 9, 2);     wait_done("ld_end");
        load_pat("o*d", 1'b1, 4, 7);     wait_done("o_star_d");
        load_pat("h*o*z", 1'b0, 0, 0);   wait_done("h_o_z");
`ifdef SME_MULTI_NOCASE_EN
        load_pat("WOR", 1'b1, 6, 3);     wait_done("upper_wor");
`else
        load_pat("WOR", 1'b0, 0, 0);     wait_done("upper_wor");
`endif

        // 9-char pattern: only "hello wo" is kept; string writes during scan ignored
        load_pat("hello woZ", 1'b1, 0, 8);
        @(posedge clk);
        #1;
        put("x", 1'b1, 1'b0);
        put("y", 1'b1, 1'b0);
        idle_in();
        wait_done("pat_trunc");
        load_pat("wor", 1'b1, 6, 3);     wait_done("wor_kept");

        s40 = "";
        for (int i = 0; i < 40; i++) s40 = {s40, "a"};
        send_str(s40);
        chk(str_ovf === 1'b1, "ovf_set", int'(str_ovf), 1);
        load_pat("a.", 1'b1, 0, 2);      wait_done("a_dot");
        // saturated at 32 chars, so the only "a" before the end sits at 31
        load_pat("a$", 1'b1, 31, 1);     wait_done("a_end");
        send_str("ab");
        chk(str_ovf === 1'b0, "ovf_clear", int'(str_ovf), 0);
        load_pat("b", 1'b1, 1, 1);       wait_done("b");

        // reset in the middle of a scan
        send_str("hello world");
        load_pat("h*o*z", 1'b0, 0, 0);
        repeat (5) @(posedge clk);
        #2;
        chk(busy === 1'b1, "busy_pre_reset", int'(busy), 1);
        reset = 1'b1;
        #1;
        chk(valid === 1'b0, "midrst_valid", int'(valid), 0);
        chk(busy === 1'b0, "midrst_busy", int'(busy), 0);
        chk(match === 1'b0, "midrst_match", int'(match), 0);
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        send_str("ab cd");
        load_pat("^cd", 1'b1, 3, 2);     wait_done("post_rst");

        repeat (3) @(posedge clk);
        chk(exp_q.size() == 0, "results_pending", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
